axis_fifo_param: RTL and testbench

- Parametrised AXI4-Stream FIFO, successor to the fixed-size FIFO_axis IP.
- Generalises data width, depth and fill thresholds.
- Adds TLAST passthrough, fill-level and almost-full/almost-empty status, synchronous flush, and an optional store-and-forward packet mode.
- Sits between a stream producer (e.g. sample acquisition front end) and a stream consumer (e.g. correlator/DMA), in the ACLK domain.

---
 rtl/axis_fifo_param_pkg.sv | 22 ++
 rtl/axis_fifo_param_if.sv | 12 +
 rtl/axis_fifo_param_ram.sv | 21 ++
 rtl/axis_fifo_param.sv | 145 ++++++++++++++
 tb/tb_axis_fifo_param.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_fifo_param_pkg.sv
// Shared width helpers, reset values and packet-mode drain states for axis_fifo_param.
package axis_fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_ACTIVE
  } drain_state_e;

  localparam logic         RST_INIT         = 1'b0;
  localparam logic         RST_ALMOST_FULL  = 1'b0;
  localparam logic         RST_ALMOST_EMPTY = 1'b1;
  localparam drain_state_e RST_DRAIN        = DRAIN_IDLE;

endpackage

// File: rtl/axis_fifo_param_if.sv
// AXI4-Stream handshake bundle; master drives data/valid/last, slave drives ready.
interface axis_fifo_param_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_fifo_param_ram.sv
// Simple dual-port storage: registered write, asynchronous read, no reset.
module axis_fifo_ram #(
  parameter int unsigned WIDTH  = 33,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/axis_fifo_param.sv
// Parametrised first-word-fall-through AXI4-Stream FIFO with level/threshold status and flush.
// Define FIFO_AXIS_PACKET_MODE_EN for store-and-forward packet mode.
module axis_fifo_param
  import axis_fifo_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH    = 32,
  parameter int unsigned C_FIFO_DEPTH          = 16,
  parameter int unsigned C_ALMOST_FULL_THRESH  = 12,
  parameter int unsigned C_ALMOST_EMPTY_THRESH = 2
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic                                   flush,
  axis_fifo_param_if.slave                       s_axis,
  axis_fifo_param_if.master                      m_axis,
  output logic [level_width(C_FIFO_DEPTH)-1:0]   level,
  output logic                                   almost_full,
  output logic                                   almost_empty
);
  localparam int unsigned PTR_W = ptr_width(C_FIFO_DEPTH);
  localparam int unsigned LVL_W = level_width(C_FIFO_DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(C_FIFO_DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(C_ALMOST_FULL_THRESH);
  localparam logic [LVL_W-1:0] AE_LVL   = LVL_W'(C_ALMOST_EMPTY_THRESH);

  typedef struct packed {
    logic                          tlast;
    logic [C_AXIS_TDATA_WIDTH-1:0] tdata;
  } entry_t;

  entry_t           wr_entry, rd_entry;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             init_q;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             s_ready, m_valid, fwd_ok, wr_fire, rd_fire;

  assign wr_entry = '{tlast: s_axis.tlast, tdata: s_axis.tdata};

  axis_fifo_ram #(
    .WIDTH  ($bits(entry_t)),
    .DEPTH  (C_FIFO_DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (ACLK),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

`ifdef FIFO_AXIS_PACKET_MODE_EN
  logic [LVL_W-1:0] pkt_cnt_q, pkt_cnt_d;
  drain_state_e     drain_q, drain_d;

  // A full FIFO holding no tlast would never release; draining forwards until a tlast leaves.
  assign fwd_ok = (pkt_cnt_q != '0) || (level_q == FULL_LVL) || (drain_q == DRAIN_ACTIVE);

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    drain_d   = drain_q;
    if (flush) begin
      pkt_cnt_d = '0;
      drain_d   = DRAIN_IDLE;
    end else begin
      case ({wr_fire && wr_entry.tlast, rd_fire && rd_entry.tlast})
        2'b10:   pkt_cnt_d = pkt_cnt_q + LVL_W'(1);
        2'b01:   pkt_cnt_d = pkt_cnt_q - LVL_W'(1);
        default: pkt_cnt_d = pkt_cnt_q;
      endcase
      case (drain_q)
        DRAIN_IDLE:   if (level_q == FULL_LVL && pkt_cnt_q == '0) drain_d = DRAIN_ACTIVE;
        DRAIN_ACTIVE: if (rd_fire && rd_entry.tlast) drain_d = DRAIN_IDLE;
        default:      drain_d = DRAIN_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pkt_cnt_q <= '0;
      drain_q   <= RST_DRAIN;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      drain_q   <= drain_d;
    end
  end
`else
  assign fwd_ok = 1'b1;
`endif

  assign s_ready = init_q && !flush && (level_q != FULL_LVL);
  assign m_valid = !flush && (level_q != '0) && fwd_ok;
  assign wr_fire = s_axis.tvalid && s_ready;
  assign rd_fire = m_valid && m_axis.tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_fire, rd_fire})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
    almost_full_d  = (level_d >= AF_LVL);
    almost_empty_d = (level_d <= AE_LVL);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      init_q         <= RST_INIT;
      almost_full_q  <= RST_ALMOST_FULL;
      almost_empty_q <= RST_ALMOST_EMPTY;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      init_q         <= 1'b1;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = rd_entry.tdata;
  assign m_axis.tlast  = rd_entry.tlast;
  assign level         = level_q;
  assign almost_full   = almost_full_q;
  assign almost_empty  = almost_empty_q;
endmodule

// File: tb/tb_axis_fifo_param.sv
// Directed + randomized bench for axis_fifo_param against a queue-based reference model.
module tb_axis_fifo_param;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] level;
  logic       almost_full, almost_empty;

  axis_fifo_param_if #(.DATA_W(W)) s_if ();
  axis_fifo_param_if #(.DATA_W(W)) m_if ();

  axis_fifo_param #(
    .C_AXIS_TDATA_WIDTH    (W),
    .C_FIFO_DEPTH          (D),
    .C_ALMOST_FULL_THRESH  (AF),
    .C_ALMOST_EMPTY_THRESH (AE)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .flush        (flush),
    .s_axis       (s_if.slave),
    .m_axis       (m_if.master),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [W:0] q[$];
  bit m_init = 1'b0;
  bit last_wr;
`ifdef FIFO_AXIS_PACKET_MODE_EN
  bit m_drain = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pkts();
    int n = 0;
    foreach (q[i]) if (q[i][W]) n++;
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    m_init = 1'b0;
`ifdef FIFO_AXIS_PACKET_MODE_EN
    m_drain = 1'b0;
`endif
  endtask

  // One clock: check combinational outputs before the edge, advance the model, check registers after.
  task automatic step();
    bit exp_ready, exp_valid, wf, rf, fl;
    logic [W:0] in_word;
`ifdef FIFO_AXIS_PACKET_MODE_EN
    bit set_drain, popped_last;
`endif
    #1;
    exp_ready = m_init && !flush && (q.size() != D);
    exp_valid = !flush && (q.size() != 0);
`ifdef FIFO_AXIS_PACKET_MODE_EN
    exp_valid = exp_valid && (pkts() != 0 || q.size() == D || m_drain);
    set_drain = (q.size() == D) && (pkts() == 0);
`endif
    chk("s_tready", s_if.tready, exp_ready);
    chk("m_tvalid", m_if.tvalid, exp_valid);
    if (exp_valid) begin
      chk("m_tdata", m_if.tdata, q[0][W-1:0]);
      chk("m_tlast", m_if.tlast, q[0][W]);
    end
    wf = exp_ready && s_if.tvalid;
    rf = exp_valid && m_if.tready;
    fl = flush;
    in_word = {s_if.tlast, s_if.tdata};
`ifdef FIFO_AXIS_PACKET_MODE_EN
    popped_last = rf && q[0][W];
`endif
    @(posedge ACLK);
    last_wr = wf;
    if (fl) begin
      q.delete();
`ifdef FIFO_AXIS_PACKET_MODE_EN
      m_drain = 1'b0;
`endif
    end else begin
      if (rf) void'(q.pop_front());
      if (wf) q.push_back(in_word);
`ifdef FIFO_AXIS_PACKET_MODE_EN
      if (m_drain) begin
        if (popped_last) m_drain = 1'b0;
      end else if (set_drain) m_drain = 1'b1;
`endif
    end
    m_init = 1'b1;
    #1;
    chk("level", level, q.size());
    chk("almost_full", almost_full, q.size() >= AF);
    chk("almost_empty", almost_empty, q.size() <= AE);
  endtask

  task automatic drain_out(input int budget);
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    for (int i = 0; i < budget && q.size() != 0; i++) step();
    chk("drain_empty", level, 0);
  endtask

  initial begin
    int nxt;
    int wcnt;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;

    // Reset state
    #12;
    chk("rst_level", level, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_almost_empty", almost_empty, 1);
    @(negedge ACLK);
    ARESETN = 1'b1;
    model_reset();

    // Fill 1..16 with output stalled, then read back in order
    nxt = 1;
    for (int i = 0; i < 40 && q.size() < D; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = nxt;
      step();
      if (last_wr) nxt++;
    end
    chk("fill_level", level, 16);
    chk("fill_almost_full", almost_full, 1);
    step();
    for (int i = 0; i < D; i++) begin
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;
      #1;
      chk("order", m_if.tdata, i + 1);
      step();
    end
    chk("read_all_level", level, 0);
    chk("read_all_almost_empty", almost_empty, 1);

    // Continuous streaming, exercising pointer wrap
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    for (int i = 0; i < 160; i++) begin
      s_if.tdata = $urandom;
      step();
    end
    chk("stream_level", level, 1);
    drain_out(20);

    // Full with simultaneous read
    m_if.tready = 1'b0;
    for (int i = 0; i < 40 && q.size() < D; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = $urandom;
      step();
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'hF00D_F00D;
    m_if.tready = 1'b1;
    step();
    chk("full_rd_level", level, 15);
    drain_out(20);

    // Empty with simultaneous write
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h1234_5678;
    step();
    chk("empty_wr_level", level, 1);
    s_if.tvalid = 1'b0;
    step();

    // Load 7 words, then flush with both handshakes active
    m_if.tready = 1'b0;
    for (int i = 0; i < 20 && q.size() < 7; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = $urandom;
      step();
    end
    flush       = 1'b1;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'hDEAD_BEEF;
    m_if.tready = 1'b1;
    step();
    flush       = 1'b0;
    s_if.tvalid = 1'b0;
    chk("flush_level", level, 0);
    step();

    // Random handshakes, tlast every 5th word, reset mid-burst
    wcnt = 0;
    last_wr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        ARESETN = 1'b0;
        #2;
        chk("midrst_m_tvalid", m_if.tvalid, 0);
        chk("midrst_s_tready", s_if.tready, 0);
        chk("midrst_level", level, 0);
        chk("midrst_almost_empty", almost_empty, 1);
        model_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
        wcnt = 0;
      end
      if (!s_if.tvalid || last_wr) begin
        s_if.tdata  = $urandom;
        s_if.tvalid = 1'($urandom_range(0, 1));
      end
      s_if.tlast  = (wcnt % 5 == 4);
      m_if.tready = 1'($urandom_range(0, 1));
      step();
      if (last_wr) wcnt++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();

`ifdef FIFO_AXIS_PACKET_MODE_EN
    // Store-and-forward: held until tlast, then drained
    m_if.tready = 1'b1;
    nxt = 0;
    for (int i = 0; i < 20 && nxt < 5; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'hA000 + nxt;
      s_if.tlast  = (nxt == 4);
      step();
      if (last_wr) nxt++;
      if (nxt < 5) chk("pkt_hold_tvalid", m_if.tvalid, 0);
    end
    s_if.tlast = 1'b0;
    drain_out(20);

    // Oversized packet without tlast escapes via draining
    nxt = 0;
    for (int i = 0; i < 80 && nxt < 20; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'hB000 + nxt;
      s_if.tlast  = 1'b0;
      step();
      if (last_wr) nxt++;
    end
    chk("pkt_big_accepted", nxt, 20);
    drain_out(40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
